add_sequencer: RTL and testbench



---
 rtl/add_sequencer.sv | 177 +++++++++++++++++
 tb/tb_add_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sequencer.sv
// Multi-cycle add/subtract controller for the slide-switch adder datapath.
// Latency: START edge, then one edge per carry step (k <= WIDTH), then one edge to publish (DONE).
// Backpressure: none; START is ignored while busy_o is high, and results hold until the next DONE.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (priority over everything)
//   start_i               level start request, sampled only while idle
//   mode_i                1 = two's complement, 0 = unsigned
//   op_i                  0 = x + y, 1 = x - y
//   x_i, y_i              operands (captured on the START edge)
//   sum_o                 raw result bits
//   mag_o                 magnitude of a negative signed result, otherwise sum_o
//   neg_o                 sign digit for the HEX display (signed mode only)
//   ovf_o                 result not representable in the selected mode/op
//   busy_o                high while the carry loop runs
//   done_o                one-cycle pulse when the outputs update
//   iters_o               carry steps taken by the last completed operation
module add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic                       op_i,
    input  logic [WIDTH-1:0]           x_i,
    input  logic [WIDTH-1:0]           y_i,
    output logic [WIDTH-1:0]           sum_o,
    output logic [WIDTH-1:0]           mag_o,
    output logic                       neg_o,
    output logic                       ovf_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(WIDTH+1)-1:0] iters_o
);

    localparam int CW  = $clog2(WIDTH+1);
    localparam int MSB = WIDTH - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mx_q, mx_d;
    logic [WIDTH-1:0] my_q, my_d;
    logic             mode_q, mode_d;
    logic             op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [CW-1:0]    iters_q, iters_d;

    // Per-step carry vector and the flags derived from the finished sum (a_q once b_q == 0).
    logic [WIDTH-1:0] carry;
    logic             res_neg;
    logic [WIDTH-1:0] res_mag;
    logic             res_ovf;

    assign carry   = a_q & b_q;
    assign res_neg = mode_q & a_q[MSB];
    // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign res_mag = res_neg ? (~a_q + WIDTH'(1)) : a_q;

    always_comb begin
        res_ovf = 1'b0;
        if (mode_q) begin
            if (op_q) res_ovf = (mx_q[MSB] != my_q[MSB]) & (a_q[MSB] != mx_q[MSB]);
            else      res_ovf = (mx_q[MSB] == my_q[MSB]) & (a_q[MSB] != mx_q[MSB]);
        end else begin
            // Unsigned subtract reports a borrow; the carry out of the negation is meaningless.
            if (op_q) res_ovf = (mx_q < my_q);
            else      res_ovf = cout_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mx_d    = mx_q;
        my_d    = my_q;
        mode_d  = mode_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        iters_d = iters_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = x_i;
                    b_d     = op_i ? (~y_i + WIDTH'(1)) : y_i;
                    mx_d    = x_i;
                    my_d    = y_i;
                    mode_d  = mode_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            default: begin
                if (b_q != '0) begin
                    a_d    = a_q ^ b_q;
                    b_d    = carry << 1;
                    cnt_d  = cnt_q + CW'(1);
                    cout_d = cout_q | carry[MSB];
                end else begin
                    state_d = S_IDLE;
                    sum_d   = a_q;
                    mag_d   = res_mag;
                    neg_d   = res_neg;
                    ovf_d   = res_ovf;
                    iters_d = cnt_q;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            mode_q  <= 1'b0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            iters_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            iters_q <= iters_d;
        end
    end

    assign sum_o   = sum_q;
    assign mag_o   = mag_q;
    assign neg_o   = neg_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == S_RUN);
    assign done_o  = done_q;
    assign iters_o = iters_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Scoreboard bench for add_sequencer: stimulus pushes expected results, a negedge monitor checks them.
// Expected DONE cycle = start-sample cycle + ITERS + 1 edges.
// Outputs are checked to hold between DONE pulses and to clear under reset.
module tb_add_sequencer;

    localparam int W    = 4;
    localparam int CW   = $clog2(W+1);
    localparam int MOD  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          op_i = 1'b0;
    logic [W-1:0]  x_i = '0;
    logic [W-1:0]  y_i = '0;
    logic [W-1:0]  sum_o, mag_o;
    logic          neg_o, ovf_o, busy_o, done_o;
    logic [CW-1:0] iters_o;

    add_sequencer #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .op_i(op_i),
        .x_i(x_i), .y_i(y_i), .sum_o(sum_o), .mag_o(mag_o), .neg_o(neg_o), .ovf_o(ovf_o),
        .busy_o(busy_o), .done_o(done_o), .iters_o(iters_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sum;
        int mag;
        int neg;
        int ovf;
        int iters;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: modular arithmetic for the sum, integer range checks for overflow,
    // and the carry-step count of the XOR/AND loop.
    function automatic exp_t model(input int mode, input int op, input int x, input int y);
        exp_t e;
        int ys, a, b, t, sx, sy, r;
        ys    = op ? ((MOD - y) % MOD) : y;
        e.sum = (x + ys) % MOD;
        a = x; b = ys; e.iters = 0;
        while (b != 0) begin
            t = a & b;
            a = a ^ b;
            b = (t << 1) % MOD;
            e.iters++;
        end
        if (mode != 0) begin
            sx = (x >= MOD/2) ? x - MOD : x;
            sy = (y >= MOD/2) ? y - MOD : y;
            r  = op ? sx - sy : sx + sy;
            e.ovf = (r < -(MOD/2) || r > MOD/2 - 1) ? 1 : 0;
        end else begin
            e.ovf = op ? ((x < y) ? 1 : 0) : ((x + y > MOD - 1) ? 1 : 0);
        end
        e.neg = (mode != 0 && e.sum >= MOD/2) ? 1 : 0;
        e.mag = e.neg ? (MOD - e.sum) % MOD : e.sum;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor
    exp_t last;
    bit   have_ref = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                chk("rst_sum", sum_o, 0);
                chk("rst_mag", mag_o, 0);
                chk("rst_neg", neg_o, 0);
                chk("rst_ovf", ovf_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_iters", iters_o, 0);
                last = '{0, 0, 0, 0, 0, 0};
                have_ref = 1;
            end else if (have_ref) begin
                if (done_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("sum", sum_o, e.sum);
                        chk("mag", mag_o, e.mag);
                        chk("neg", neg_o, e.neg);
                        chk("ovf", ovf_o, e.ovf);
                        chk("iters", iters_o, e.iters);
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_at_done", busy_o, 0);
                        last = e;
                    end
                end else begin
                    chk("hold_sum", sum_o, last.sum);
                    chk("hold_mag", mag_o, last.mag);
                    chk("hold_neg", neg_o, last.neg);
                    chk("hold_ovf", ovf_o, last.ovf);
                    chk("hold_iters", iters_o, last.iters);
                end
            end
        end
    end

    // Stimulus changes 1 time unit after the falling edge, after the monitor has sampled.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 60) begin
            tick();
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input int mode, input int op, input int x, input int y);
        exp_t e;
        wait_idle();
        mode_i  = mode[0];
        op_i    = op[0];
        x_i     = W'(x);
        y_i     = W'(y);
        start_i = 1'b1;
        e       = model(mode, op, x, y);
        e.cyc   = cyc + e.iters + 2;
        q.push_back(e);
        tick();
        start_i = 1'b0;
        // Mid-op input changes must not disturb the captured operands.
        mode_i  = 1'($urandom);
        op_i    = 1'($urandom);
        x_i     = W'($urandom);
        y_i     = W'($urandom);
    endtask

    initial begin
        int n0, n;
        exp_t e;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // Directed vectors
        do_op(0, 0, 3, 4);
        do_op(1, 0, 7, 1);
        do_op(0, 0, 7, 1);
        do_op(1, 0, 15, 15);
        do_op(0, 0, 15, 15);
        do_op(1, 1, 5, 3);
        do_op(1, 1, 0, 8);
        do_op(0, 1, 3, 5);
        do_op(0, 1, 5, 5);
        do_op(0, 0, 0, 0);

        // START held high: back-to-back zero-step operations
        wait_idle();
        tick();
        wait_idle();
        n0 = cyc;
        mode_i = 1'b0; op_i = 1'b0; x_i = '0; y_i = '0; start_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            e = model(0, 0, 0, 0);
            e.cyc = n0 + 2 * k;
            q.push_back(e);
        end
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("b2b_busy", busy_o, j % 2);
        end
        start_i = 1'b0;

        // START during BUSY is ignored
        do_op(1, 0, 7, 1);
        mode_i = 1'b0; op_i = 1'b1; x_i = 3; y_i = 3; start_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;

        // Reset mid-loop: no DONE, outputs cleared (checked by the monitor)
        wait_idle();
        tick();
        mode_i = 1'b1; op_i = 1'b0; x_i = 7; y_i = 1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        tick();

        // Randomized operations with random gaps
        for (int i = 0; i < 60; i++) begin
            do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
            n = int'($urandom_range(0, 2));
            repeat (n) tick();
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("queue_drain", q.size(), 0);
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
